// File: rtl/lsu_mem_access.sv
// Load/store unit: byte-lane-correct data memory access with alignment checks and load extension.
// Latency: start at cycle 0 -> mem_req at cycle 1, ack at cycle k -> done at k+1; illegal request -> done at cycle 1.
// Backpressure: memory stalls via mem_ack (bounded by TIMEOUT_CYCLES); start is ignored while busy, no queueing.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   start, is_store, funct3,
//   addr, wdata             request from control FSM, sampled together with start
//   busy, done, fault       handshake back to the FSM (fault qualified by done)
//   rdata                   extended load result, held until the next completed load
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata, mem_rdata, mem_ack
//                           data memory port (req/ack)
module lsu_mem_access #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Last counter value before abort; comparing against it avoids needing
  // the counter to actually hold TIMEOUT_CYCLES.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [1:0]           off_q, off_d;
  logic                 fault_q, fault_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [3:0]           mem_be_q, mem_be_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;

  // Request decode on the live inputs (only consumed when start is taken in IDLE).
  logic        f3_ok;
  logic        align_ok;
  logic        req_legal;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  always_comb begin
    f3_ok      = 1'b0;
    align_ok   = 1'b0;
    be_calc    = 4'b0000;
    wdata_calc = 32'h0;

    if (is_store) begin
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      f3_ok = !((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
    end

    // funct3[1:0] is the access size for every legal code.
    case (funct3[1:0])
      2'b00: begin
        align_ok   = 1'b1;
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        align_ok   = !addr[0];
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata[15:0]}};
      end
      2'b10: begin
        align_ok   = (addr[1:0] == 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
      default: begin
        align_ok   = 1'b0;
        be_calc    = 4'b0000;
        wdata_calc = 32'h0;
      end
    endcase

    if (!is_store) begin
      wdata_calc = 32'h0;
    end

    req_legal = f3_ok && align_ok;
  end

  // Load lane extraction from the returned word, using the latched request.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    fault_d     = fault_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          funct3_d = funct3;
          off_d    = addr[1:0];
          cnt_d    = '0;
          if (req_legal) begin
            // Memory port is only touched for legal requests, so an
            // illegal one leaves the port completely quiet.
            state_d     = S_ACCESS;
            fault_d     = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = be_calc;
            mem_wdata_d = wdata_calc;
          end else begin
            state_d = S_DONE;
            fault_d = 1'b1;
          end
        end
      end

      S_ACCESS: begin
        if (mem_ack) begin
          state_d   = S_DONE;
          fault_d   = 1'b0;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d = load_ext;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          fault_d   = 1'b1;
          mem_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        fault_d = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        fault_d   = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      fault_q     <= 1'b0;
      rdata_q     <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign fault     = fault_q;  // only ever set while in DONE
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: stores, loads with extension, illegal requests,
// delayed ack, timeout abort and asynchronous reset during an access.
module tb_lsu_mem_access;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int vectors     = 0;
  int miscompares = 0;

  lsu_mem_access #(
    .TIMEOUT_CYCLES(16),
    .CNT_WIDTH     (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .rdata    (rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven
  // and outputs sampled at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns at cycle 1 relative to acceptance.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    start    = 1'b1;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    tick();
    start    = 1'b0;
    is_store = 1'b0;
    funct3   = 3'b000;
    addr     = 32'h0;
    wdata    = 32'h0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_store  = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;

    #3;
    check("rst_busy",    {31'b0, busy},    32'h0);
    check("rst_done",    {31'b0, done},    32'h0);
    check("rst_fault",   {31'b0, fault},   32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_we",  {31'b0, mem_we},  32'h0);
    check("rst_rdata",   rdata,            32'h0);
    check("rst_mem_be",  {28'b0, mem_be},  32'h0);
    check("rst_mem_wd",  mem_wdata,        32'h0);

    tick();
    tick();
    reset = 1'b0;
    tick();

    // sb to byte 3, ack in the first request cycle.
    issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
    check("sb_c1_req",   {31'b0, mem_req}, 32'h1);
    check("sb_c1_we",    {31'b0, mem_we},  32'h1);
    check("sb_c1_addr",  mem_addr,         32'h0000_1000);
    check("sb_c1_be",    {28'b0, mem_be},  32'h8);
    check("sb_c1_wdata", mem_wdata,        32'hABAB_ABAB);
    check("sb_c1_busy",  {31'b0, busy},    32'h1);
    check("sb_c1_done",  {31'b0, done},    32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_c2_done",  {31'b0, done},    32'h1);
    check("sb_c2_fault", {31'b0, fault},   32'h0);
    check("sb_c2_req",   {31'b0, mem_req}, 32'h0);
    check("sb_c2_busy",  {31'b0, busy},    32'h1);
    tick();
    check("sb_c3_busy",  {31'b0, busy},    32'h0);
    check("sb_c3_done",  {31'b0, done},    32'h0);

    // lb from byte 2 of 0x12F45678 -> sign-extended 0xF4.
    issue(1'b0, 3'b000, 32'h0000_2002, 32'hFFFF_FFFF);
    check("lb_c1_be",    {28'b0, mem_be},  32'h4);
    check("lb_c1_we",    {31'b0, mem_we},  32'h0);
    check("lb_c1_wdata", mem_wdata,        32'h0);
    check("lb_c1_addr",  mem_addr,         32'h0000_2000);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12F4_5678;
    tick();
    mem_ack = 1'b0;
    check("lb_c2_done",  {31'b0, done},    32'h1);
    check("lb_rdata",    rdata,            32'hFFFF_FFF4);
    tick();

    // Same access as lbu -> zero-extended.
    issue(1'b0, 3'b100, 32'h0000_2002, 32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lbu_rdata",   rdata,            32'h0000_00F4);
    check("lbu_fault",   {31'b0, fault},   32'h0);
    tick();

    // lh / lhu from the upper half.
    issue(1'b0, 3'b001, 32'h0000_2002, 32'h0);
    check("lh_c1_be",    {28'b0, mem_be},  32'hC);
    mem_ack   = 1'b1;
    mem_rdata = 32'h8001_0000;
    tick();
    mem_ack = 1'b0;
    check("lh_rdata",    rdata,            32'hFFFF_8001);
    tick();
    issue(1'b0, 3'b101, 32'h0000_2002, 32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lhu_rdata",   rdata,            32'h0000_8001);
    tick();

    // sh to the low half: lane replication.
    issue(1'b1, 3'b001, 32'h0000_3000, 32'h1234_BEEF);
    check("sh_c1_be",    {28'b0, mem_be},  32'h3);
    check("sh_c1_wdata", mem_wdata,        32'hBEEF_BEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sh_rdata_kept", rdata,          32'h0000_8001);
    tick();

    // Misaligned lh: immediate fault, no memory cycle, rdata kept.
    issue(1'b0, 3'b001, 32'h0000_2001, 32'h0);
    check("mis_c1_done",  {31'b0, done},    32'h1);
    check("mis_c1_fault", {31'b0, fault},   32'h1);
    check("mis_c1_req",   {31'b0, mem_req}, 32'h0);
    check("mis_rdata",    rdata,            32'h0000_8001);
    tick();
    check("mis_c2_busy",  {31'b0, busy},    32'h0);
    check("mis_c2_fault", {31'b0, fault},   32'h0);

    // Store with a load-only funct3 is illegal.
    issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
    check("sbu_fault",    {31'b0, fault},   32'h1);
    check("sbu_req",      {31'b0, mem_req}, 32'h0);
    tick();

    // Misaligned lw.
    issue(1'b0, 3'b010, 32'h0000_0012, 32'h0);
    check("lwmis_fault",  {31'b0, fault},   32'h1);
    tick();

    // lw with ack at cycle 4; extra start at cycle 2 must be ignored.
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    check("lw_c1_req",  {31'b0, mem_req}, 32'h1);
    check("lw_c1_be",   {28'b0, mem_be},  32'hF);
    tick();
    start    = 1'b1;
    is_store = 1'b1;
    funct3   = 3'b000;
    addr     = 32'h0000_5555;
    wdata    = 32'h0000_0077;
    check("lw_c2_req",  {31'b0, mem_req}, 32'h1);
    tick();
    start    = 1'b0;
    is_store = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    check("lw_c3_req",  {31'b0, mem_req}, 32'h1);
    check("lw_c3_addr", mem_addr,         32'h0000_0010);
    check("lw_c3_we",   {31'b0, mem_we},  32'h0);
    check("lw_c3_be",   {28'b0, mem_be},  32'hF);
    tick();
    check("lw_c4_req",  {31'b0, mem_req}, 32'h1);
    check("lw_c4_done", {31'b0, done},    32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    check("lw_c5_done",  {31'b0, done},    32'h1);
    check("lw_c5_fault", {31'b0, fault},   32'h0);
    check("lw_rdata",    rdata,            32'hDEAD_BEEF);
    tick();
    check("lw_c6_busy",  {31'b0, busy},    32'h0);
    check("lw_c6_req",   {31'b0, mem_req}, 32'h0);

    // ack while idle is ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_busy",  {31'b0, busy}, 32'h0);
    check("idle_ack_rdata", rdata,         32'hDEAD_BEEF);

    // sw with no ack: 16 request cycles, then fault.
    issue(1'b1, 3'b010, 32'h0000_0040, 32'h1122_3344);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("to_req_c%0d", i), {31'b0, mem_req}, 32'h1);
      tick();
    end
    check("to_c17_req",   {31'b0, mem_req}, 32'h0);
    check("to_c17_done",  {31'b0, done},    32'h1);
    check("to_c17_fault", {31'b0, fault},   32'h1);
    check("to_c17_busy",  {31'b0, busy},    32'h1);
    check("to_rdata",     rdata,            32'hDEAD_BEEF);
    tick();
    check("to_c18_busy",  {31'b0, busy},    32'h0);
    check("to_c18_done",  {31'b0, done},    32'h0);

    // Reset in the middle of an access.
    issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
    check("rst_mid_c1_req", {31'b0, mem_req}, 32'h1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_req",   {31'b0, mem_req}, 32'h0);
    check("rst_mid_busy",  {31'b0, busy},    32'h0);
    check("rst_mid_rdata", rdata,            32'h0);
    tick();
    reset = 1'b0;
    tick();

    // lbu from byte 1 after reset.
    issue(1'b0, 3'b100, 32'h0000_3001, 32'h0);
    check("post_c1_req", {31'b0, mem_req}, 32'h1);
    check("post_c1_be",  {28'b0, mem_be},  32'h2);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_AB00;
    tick();
    mem_ack = 1'b0;
    check("post_c2_done", {31'b0, done},   32'h1);
    check("post_rdata",   rdata,           32'h0000_00AB);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
Load/store unit placed directly downstream of the multicycle control FSM. The FSM issues a `start` pulse in its MEMREAD or MEMWRITE state. The unit then runs a byte-lane-correct access on the data memory port and returns extended load data to the MEMWB write-back path. It performs alignment checks, byte-enable generation, store-data lane replication and load sign/zero extension. Memory handshake is req/ack with a bounded wait; the FSM stalls on `busy`.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in ACCESS without `mem_ack` before aborting with fault (must be >= 1)
CNT_WIDTH, 5, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  single-cycle request from control FSM
is_store  in  1  1 = store, 0 = load; sampled with start
funct3  in  3  RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu); sampled with start
addr  in  32  byte address (ALU result); sampled with start
wdata  in  32  rs2 value for stores; sampled with start
busy  out  1  high from the cycle after accepted start until done cycle inclusive
done  out  1  one-cycle completion pulse
fault  out  1  valid only with done; misaligned, illegal funct3 or timeout
rdata  out  32  extended load result; held until next completed load
mem_req  out  1  memory request, held until ack/abort
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid when mem_ack high
mem_ack  in  1  memory accepts/completes access in this cycle

Behaviour:
- Reset (async): state IDLE, busy/done/fault/mem_req/mem_we = 0, mem_addr/mem_be/mem_wdata = 0, rdata = 0, counter = 0. Reset during ACCESS drops mem_req immediately.
- FSM: IDLE -> (start) ACCESS or DONE; ACCESS -> (mem_ack or timeout) DONE; DONE -> IDLE.
- IDLE on start: latch all inputs.
  - If the request is legal, go to ACCESS; mem_req is registered high in the next cycle.
  - If illegal, go straight to DONE with fault=1 and no memory cycle.
  - Illegal: store funct3 not in {000,001,010}; load funct3 in {011,110,111}; halfword with addr[0]=1; word with addr[1:0]!=0.
- start while busy is ignored; no queueing.
- ACCESS: mem_req, mem_we, mem_addr, mem_be and mem_wdata are constant for the whole state.
  - Counter increments each ACCESS cycle without ack.
  - mem_ack sampled high: for loads, capture extracted rdata; go to DONE with fault=0.
  - Counter reaches TIMEOUT_CYCLES with no ack: deassert mem_req, go to DONE with fault=1, leave rdata unchanged.
  - mem_ack outside ACCESS is ignored.
- DONE: done=1 and busy=1 for exactly one cycle; fault is driven; mem_req=0.
- Latency, start accepted at cycle 0: mem_req high at cycle 1; ack at cycle k (k>=1) gives done at cycle k+1. Zero-wait access gives done at cycle 2. Illegal request gives done at cycle 1.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: addr[1]=0 -> 0011, addr[1]=1 -> 1100.
  - word: 1111.
  - Loads drive the same mem_be as stores.
- Store data: byte replicated as {4{wdata[7:0]}}; half as {2{wdata[15:0]}}; word unchanged. Loads drive mem_wdata = 0.
- Load extract: select lane by addr[1:0] (byte) or addr[1] (half). lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.

Test Plan:
- sb addr=0x00001003 wdata=0x000000AB, ack in first req cycle -> mem_addr=0x00001000, mem_be=1000, mem_wdata=0xABABABAB, mem_we=1, done at cycle 2, fault=0.
- lb addr=0x00002002, mem_rdata=0x12F45678 -> rdata=0xFFFFFFF4, mem_be=0100; repeat as lbu -> rdata=0x000000F4.
- lh addr=0x00002001 -> done with fault=1 at cycle 1, mem_req never asserted, rdata unchanged.
- lw addr=0x00000010, ack delayed 3 cycles, mem_rdata=0xDEADBEEF -> mem_req high 4 cycles with all outputs stable, rdata=0xDEADBEEF, done at cycle 5; a second start pulse during busy is ignored.
- sw with no ack, TIMEOUT_CYCLES=16 -> mem_req drops after 16 req cycles, done+fault pulse, busy falls next cycle.
- Reset asserted mid-ACCESS -> mem_req/busy fall asynchronously, rdata=0; first start after deassert behaves normally.
